prime_seq_checker: RTL and testbench
====================================

PRIME_SEQ_CHECKER -- requirements
Module: prime_seq_checker

Receive-side monitor for the 3-bit prime-step counter stream (legal cycle 0 -> 2 -> 3 -> 5 -> 7 -> 0).

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, setting the width of err_count and wrap_count.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, in_count is sampled on a clk edge only when high.
REQ-005 The block SHALL have port in_count, input, 3, observed counter value.
REQ-006 The block SHALL have port clr_counts, input, 1, synchronous clear of err_count and wrap_count.
REQ-007 The block SHALL have port locked, output, 1, high while in LOCKED state.
REQ-008 The block SHALL have port err_pulse, output, 1, one-cycle flag for a sequence violation detected in LOCKED.
REQ-009 The block SHALL have port expected, output, 3, next value the checker expects.
REQ-010 The block SHALL have port err_count, output, ERR_W, saturating violation count.
REQ-011 The block SHALL have port wrap_count, output, ERR_W, count of completed cycles, wrapping modulo 2^ERR_W.

Function
REQ-012 The checker SHALL define next(v) as follows: 0->2, 2->3, 3->5, 5->7, 7->0; values 1, 4 and 6 SHALL be illegal.
REQ-013 The block SHALL contain a state machine with three states: HUNT, VERIFY and LOCKED.
REQ-014 All outputs SHALL be registered and SHALL update on the clk edge that samples in_valid=1.
REQ-015 With in_valid=0, state, expected, and both counters SHALL hold, and err_pulse SHALL be 0.
REQ-016 In HUNT, a valid legal sample v SHALL set expected=next(v) and move to VERIFY.
REQ-017 In HUNT, a valid illegal sample SHALL leave the state at HUNT and leave expected unchanged.
REQ-018 In VERIFY, a sample equal to expected SHALL move to LOCKED and set expected=next(sample).
REQ-019 In VERIFY, a mismatching legal sample SHALL re-seed expected=next(sample) and stay in VERIFY.
REQ-020 In VERIFY, a mismatching illegal sample SHALL move to HUNT.
REQ-021 HUNT and VERIFY SHALL never assert err_pulse or change err_count.
REQ-022 In LOCKED, a matching sample SHALL set expected=next(sample) and stay in LOCKED.
REQ-023 In LOCKED, a matching sample of 0 SHALL also increment wrap_count by 1, wrapping from all-ones to 0.
REQ-024 In LOCKED, any mismatch SHALL assert err_pulse for exactly one cycle and move to HUNT.
REQ-025 A LOCKED mismatch SHALL increment err_count, saturating at 2^ERR_W-1 with no wrap.
REQ-026 A LOCKED mismatch SHALL leave expected holding its prior value.
REQ-027 locked SHALL equal 1 exactly when the state is LOCKED, with no extra cycle of latency relative to the state register.
REQ-028 Detection latency SHALL be 1 cycle: err_pulse is high in the cycle following the edge that sampled the bad value.
REQ-029 If clr_counts coincides with an error or a wrap event, clr_counts SHALL win (the affected counter becomes 0), while err_pulse and the state transition SHALL still occur.
REQ-030 clr_counts SHALL NOT affect state, expected, or locked.
REQ-031 Back-to-back valid samples, one per cycle, SHALL be supported with no stall and no ready signal.

Reset
REQ-032 reset SHALL take priority over in_valid and clr_counts.
REQ-033 On reset the block SHALL enter HUNT with locked=0, err_pulse=0, expected=3'b000, err_count=0 and wrap_count=0.
REQ-034 Reset asserted mid-sequence SHALL discard lock, and the block SHALL require a fresh HUNT -> VERIFY -> LOCKED progression after reset.

Verification
REQ-035 Clean stream: reset, then valid 0,2,3,5,7,0,2 on consecutive cycles -> locked rises after the sample 2 (second sample); wrap_count=1 after the second 0; err_pulse never asserted.
REQ-036 Violation in LOCKED: lock on 0,2,3, then feed 4 -> err_pulse=1 for one cycle, err_count=1, locked=0, expected stays 5.
REQ-037 Gaps: locked stream with in_valid deasserted for 5 cycles between 3 and 5 -> no error, state unchanged, expected=5 throughout the gap.
REQ-038 Resync: in HUNT feed 1,6 (stay HUNT), then 5,2 (re-seed in VERIFY, expected=3), then 3 -> LOCKED, err_count unchanged.
REQ-039 Saturation and clear: with ERR_W=2, force 5 LOCKED violations -> err_count stays 3; clr_counts asserted in the same cycle as a violation -> err_count=0 and err_pulse=1.
REQ-040 Mid-operation reset: reset while LOCKED with wrap_count=2 -> all outputs return to reset values on the next edge; next sample 7 goes to VERIFY with expected=0.

Source files
------------

// File: rtl/prime_seq_checker.sv
// -----------------------------------------------------------------------------
// prime_seq_checker
//
// Receive-side monitor for a 3-bit prime-step counter stream whose legal
// cycle is 0 -> 2 -> 3 -> 5 -> 7 -> 0.  The checker hunts for a legal value,
// verifies a second consecutive step, and then tracks the stream while
// locked.  Any deviation while locked produces a one-cycle error pulse and a
// return to hunting.
//
// Ports
//   clk         : rising-edge clock for all state
//   reset       : synchronous, active-high reset (highest priority)
//   in_valid    : in_count is sampled on a clk edge only when high
//   in_count    : observed counter value
//   clr_counts  : synchronous clear of err_count and wrap_count
//   locked      : high while the FSM is in LOCKED
//   err_pulse   : one-cycle flag for a violation detected while LOCKED
//   expected    : next value the checker expects
//   err_count   : saturating violation count (ERR_W bits)
//   wrap_count  : completed-cycle count, wraps modulo 2^ERR_W (ERR_W bits)
// -----------------------------------------------------------------------------
module prime_seq_checker #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_count,
  input  logic             clr_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [2:0]       expected,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] CNT_ZERO = {ERR_W{1'b0}};

  // True for the five values that appear in the legal cycle.
  function automatic logic is_legal(input logic [2:0] v);
    logic ok;
    case (v)
      3'd0, 3'd2, 3'd3, 3'd5, 3'd7: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Successor in the legal cycle; illegal inputs map to 0 but are never used
  // to seed expected because callers check legality first.
  function automatic logic [2:0] next_val(input logic [2:0] v);
    logic [2:0] n;
    case (v)
      3'd0:    n = 3'd2;
      3'd2:    n = 3'd3;
      3'd3:    n = 3'd5;
      3'd5:    n = 3'd7;
      3'd7:    n = 3'd0;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  state_t           state_q,      state_d;
  logic [2:0]       expected_q,   expected_d;
  logic             err_pulse_q,  err_pulse_d;
  logic [ERR_W-1:0] err_count_q,  err_count_d;
  logic [ERR_W-1:0] wrap_count_q, wrap_count_d;

  logic             match_s;
  logic             legal_s;

  assign match_s = (in_count == expected_q);
  assign legal_s = is_legal(in_count);

  // Next-state, expected-value and counter update logic.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (legal_s) begin
            expected_d = next_val(in_count);
            state_d    = ST_VERIFY;
          end else begin
            state_d    = ST_HUNT;
          end
        end

        ST_VERIFY: begin
          // expected_q is always legal here, so a match implies a legal sample.
          if (match_s) begin
            expected_d = next_val(in_count);
            state_d    = ST_LOCKED;
          end else if (legal_s) begin
            expected_d = next_val(in_count);
            state_d    = ST_VERIFY;
          end else begin
            state_d    = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          if (match_s) begin
            expected_d = next_val(in_count);
            state_d    = ST_LOCKED;
            if (in_count == 3'd0) begin
              wrap_count_d = wrap_count_q + CNT_ONE;
            end else begin
              wrap_count_d = wrap_count_q;
            end
          end else begin
            // expected deliberately holds so the missed value stays visible.
            err_pulse_d = 1'b1;
            state_d     = ST_HUNT;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_ONE;
            end else begin
              err_count_d = err_count_q;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Clear beats a coincident increment; the pulse and transition still happen.
    if (clr_counts) begin
      err_count_d  = CNT_ZERO;
      wrap_count_d = CNT_ZERO;
    end else begin
      err_count_d  = err_count_d;
      wrap_count_d = wrap_count_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      expected_q   <= 3'd0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= CNT_ZERO;
      wrap_count_q <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // locked is a direct decode of the state register, so it tracks it exactly.
  assign locked     = (state_q == ST_LOCKED);
  assign err_pulse  = err_pulse_q;
  assign expected   = expected_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

  prime_seq_checker_sva u_sva (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .err_pulse (err_pulse),
    .expected  (expected)
  );

endmodule

// -----------------------------------------------------------------------------
// prime_seq_checker_sva
//
// Structural invariants of prime_seq_checker: an error pulse never lasts more
// than one cycle, the block is never locked while flagging an error, and the
// expected value is always a member of the legal cycle.
//
// Ports
//   clk, reset : clock and synchronous reset of the observed block
//   locked     : observed locked flag
//   err_pulse  : observed error pulse
//   expected   : observed expected value
// -----------------------------------------------------------------------------
module prime_seq_checker_sva (
  input logic       clk,
  input logic       reset,
  input logic       locked,
  input logic       err_pulse,
  input logic [2:0] expected
);

  a_pulse_one_cycle : assert property (@(posedge clk) disable iff (reset)
    err_pulse |=> !err_pulse);

  a_pulse_not_locked : assert property (@(posedge clk) disable iff (reset)
    err_pulse |-> !locked);

  a_expected_legal : assert property (@(posedge clk) disable iff (reset)
    (expected == 3'd0) || (expected == 3'd2) || (expected == 3'd3) ||
    (expected == 3'd5) || (expected == 3'd7));

endmodule

// File: tb/tb_prime_seq_checker.sv
module tb_prime_seq_checker;

  localparam int ERR_W = 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [2:0]       in_count;
  logic             clr_counts;
  logic             locked;
  logic             err_pulse;
  logic [2:0]       expected;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] wrap_count;

  typedef struct packed {
    logic             lk;
    logic             ep;
    logic [2:0]       ex;
    logic [ERR_W-1:0] ec;
    logic [ERR_W-1:0] wc;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   vec_no;

  prime_seq_checker #(.ERR_W(ERR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_count   (in_count),
    .clr_counts (clr_counts),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .expected   (expected),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic step(input logic r, input logic v, input logic [2:0] c,
                      input logic clr, input logic el, input logic ep,
                      input logic [2:0] ee, input logic [ERR_W-1:0] ec,
                      input logic [ERR_W-1:0] wc);
    exp_t e;
    @(negedge clk);
    reset      = r;
    in_valid   = v;
    in_count   = c;
    clr_counts = clr;
    e.lk = el;
    e.ep = ep;
    e.ex = ee;
    e.ec = ec;
    e.wc = wc;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare DUT outputs to the oldest entry.
  initial begin
    exp_t e;
    vec_no = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec_no++;
        checks++;
        if ((locked !== e.lk) || (err_pulse !== e.ep) || (expected !== e.ex) ||
            (err_count !== e.ec) || (wrap_count !== e.wc)) begin
          errors++;
          $display("FAIL vec%0d got lk=%0b ep=%0b ex=%0d ec=%0d wc=%0d want lk=%0b ep=%0b ex=%0d ec=%0d wc=%0d",
                   vec_no, locked, err_pulse, expected, err_count, wrap_count,
                   e.lk, e.ep, e.ex, e.ec, e.wc);
        end
      end
    end
  end

  initial begin
    logic [ERR_W-1:0] w;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_count   = 3'd0;
    clr_counts = 1'b0;

    //    rst   vld   cnt   clr   lk    ep    ex    ec     wc
    // Reset wins over valid and clear.
    step(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0);
    // Clean stream 0,2,3,5,7,0,2.
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd5, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 3'd7, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, 2'd1);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0, 2'd1);
    // Gap of five idle cycles between 3 and 5 while locked.
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd5, 2'd0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 3'd5, 2'd0, 2'd1);
    end
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 3'd7, 2'd0, 2'd1);

    // Violation in LOCKED: reset, lock on 0,2,3, then 4.
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd5, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 3'd5, 2'd1, 2'd0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 2'd1, 2'd0);

    // Resync: illegal 1,6 in HUNT, then 5,2 re-seed, then 3 locks.
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd5, 2'd1, 2'd0);
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd5, 2'd1, 2'd0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd7, 2'd1, 2'd0);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd3, 2'd1, 2'd0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd5, 2'd1, 2'd0);

    // Saturation: violations 2..5 with re-locks between them.
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 3'd5, 2'd2, 2'd0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd7, 2'd2, 2'd0);
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 2'd0);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 3'd0, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd3, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 3'd3, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd5, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 3'd7, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd7, 2'd3, 2'd0);
    // Lock through 7,0 (no wrap: the 0 is seen in VERIFY), then clear + error.
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd3, 2'd0);
    step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 3'd2, 2'd0, 2'd0);

    // VERIFY with an illegal sample returns to HUNT: next 5 only seeds.
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd5, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd5, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0);
    // Lock on 7, then a wrap coinciding with clear leaves wrap_count at 0.
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd2, 2'd0, 2'd0);

    // Two full cycles -> wrap_count=2, then reset mid-sequence.
    w = 2'd0;
    for (int k = 1; k <= 2; k++) begin
      step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0, w);
      step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd5, 2'd0, w);
      step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 3'd7, 2'd0, w);
      step(1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, w);
      w = w + 2'd1;
      step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, w);
    end
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, 2'd0);

    // Four full cycles while locked: wrap_count runs 1,2,3 then wraps to 0.
    w = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0, w);
      step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd5, 2'd0, w);
      step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 3'd7, 2'd0, w);
      step(1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, w);
      w = w + 2'd1;
      step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, w);
    end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, 2'd0);

    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
